// File: rtl/mem_access.sv
// mem_access: load/store stage over a req/ack data bus; `MEM_LANE_CHK_EN adds a byte-lane legality check.
// Latency: 1 edge for pass-through, >=2 edges for memory ops; mem_busy stalls upstream while a transfer waits.
module mem_access #(
   parameter int ADDR_W  = 32,
   parameter int TIMEOUT = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [4:0]        EX_rd,
   input  logic              EX_rd_vld,
   input  logic [31:0]       EX_x_rd,
   input  logic [31:0]       EX_MEM_addr,
   input  logic [3:0]        EX_MEM_rden,
   input  logic              EX_MEM_rden_SEXT,
   input  logic [3:0]        EX_MEM_wren,
   input  logic [31:0]       EX_MEM_wrdata,
   output logic              dbus_req,
   output logic              dbus_we,
   output logic [ADDR_W-1:0] dbus_addr,
   output logic [3:0]        dbus_be,
   output logic [31:0]       dbus_wdata,
   input  logic              dbus_ack,
   input  logic [31:0]       dbus_rdata,
   output logic              mem_busy,
   output logic [4:0]        MEM_rd,
   output logic              MEM_rd_vld,
   output logic [31:0]       MEM_x_rd,
   output logic              MEM_err
);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

   state_t            state_q, state_d;
   logic              req_q, req_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [3:0]        be_q, be_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [4:0]        rd_q, rd_d;
   logic              rd_vld_q, rd_vld_d;
   logic [31:0]       x_rd_q, x_rd_d;
   logic              err_q, err_d;
   logic              pend_vld_q, pend_vld_d;
   logic              sext_q, sext_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              lane_illegal;
   logic              timeout_hit;
   logic              unused_addr_bits;

   assign unused_addr_bits = ^EX_MEM_addr[1:0];

   // Unlisted lane patterns fall back to the masked, unshifted word.
   function automatic logic [31:0] extract(input logic [31:0] rdata, input logic [3:0] lanes,
                                           input logic sext);
      logic [31:0] r;
      r = rdata & {{8{lanes[3]}}, {8{lanes[2]}}, {8{lanes[1]}}, {8{lanes[0]}}};
      case (lanes)
         4'b1111: r = rdata;
         4'b0011: r = {{16{sext & rdata[15]}}, rdata[15:0]};
         4'b1100: r = {{16{sext & rdata[31]}}, rdata[31:16]};
         4'b0001: r = {{24{sext & rdata[7]}},  rdata[7:0]};
         4'b0010: r = {{24{sext & rdata[15]}}, rdata[15:8]};
         4'b0100: r = {{24{sext & rdata[23]}}, rdata[23:16]};
         4'b1000: r = {{24{sext & rdata[31]}}, rdata[31:24]};
         default: ;
      endcase
      return r;
   endfunction

`ifdef MEM_LANE_CHK_EN
   logic [3:0] act_lanes;

   function automatic logic lane_ok(input logic [3:0] l);
      return l inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
   endfunction

   always_comb begin
      act_lanes    = (EX_MEM_wren != 4'b0) ? EX_MEM_wren : EX_MEM_rden;
      lane_illegal = ((EX_MEM_rden != 4'b0) && (EX_MEM_wren != 4'b0)) ||
                     ((act_lanes != 4'b0) && !lane_ok(act_lanes));
   end
`else
   assign lane_illegal = 1'b0;
`endif

   assign timeout_hit = (TIMEOUT > 0) && (cnt_q == CNT_LAST);

   always_comb begin
      state_d    = state_q;
      req_d      = req_q;
      we_d       = we_q;
      addr_d     = addr_q;
      be_d       = be_q;
      wdata_d    = wdata_q;
      rd_d       = rd_q;
      rd_vld_d   = rd_vld_q;
      x_rd_d     = x_rd_q;
      err_d      = 1'b0;
      pend_vld_d = pend_vld_q;
      sext_d     = sext_q;
      cnt_d      = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (lane_illegal) begin
               err_d    = 1'b1;
               rd_vld_d = 1'b0;
            end else if ((EX_MEM_wren != 4'b0) || (EX_MEM_rden != 4'b0)) begin
               // Store wins when both enables are set.
               we_d       = (EX_MEM_wren != 4'b0);
               be_d       = (EX_MEM_wren != 4'b0) ? EX_MEM_wren : EX_MEM_rden;
               req_d      = 1'b1;
               addr_d     = {EX_MEM_addr[ADDR_W-1:2], 2'b00};
               wdata_d    = EX_MEM_wrdata;
               rd_d       = EX_rd;
               rd_vld_d   = 1'b0;
               pend_vld_d = EX_rd_vld;
               sext_d     = EX_MEM_rden_SEXT;
               cnt_d      = '0;
               state_d    = S_WAIT;
            end else begin
               rd_d     = EX_rd;
               rd_vld_d = EX_rd_vld;
               x_rd_d   = EX_x_rd;
            end
         end
         S_WAIT: begin
            if (dbus_ack) begin
               req_d   = 1'b0;
               cnt_d   = '0;
               state_d = S_IDLE;
               if (!we_q) begin
                  x_rd_d   = extract(dbus_rdata, be_q, sext_q);
                  rd_vld_d = pend_vld_q;
               end else begin
                  rd_vld_d = 1'b0;
               end
            end else if (timeout_hit) begin
               req_d    = 1'b0;
               err_d    = 1'b1;
               rd_vld_d = 1'b0;
               cnt_d    = '0;
               state_d  = S_IDLE;
            end else if (TIMEOUT > 0) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         req_q      <= 1'b0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         be_q       <= 4'b0;
         wdata_q    <= 32'b0;
         rd_q       <= 5'b0;
         rd_vld_q   <= 1'b0;
         x_rd_q     <= 32'b0;
         err_q      <= 1'b0;
         pend_vld_q <= 1'b0;
         sext_q     <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         req_q      <= req_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         be_q       <= be_d;
         wdata_q    <= wdata_d;
         rd_q       <= rd_d;
         rd_vld_q   <= rd_vld_d;
         x_rd_q     <= x_rd_d;
         err_q      <= err_d;
         pend_vld_q <= pend_vld_d;
         sext_q     <= sext_d;
         cnt_q      <= cnt_d;
      end
   end

   assign dbus_req   = req_q;
   assign dbus_we    = we_q;
   assign dbus_addr  = addr_q;
   assign dbus_be    = be_q;
   assign dbus_wdata = wdata_q;
   assign mem_busy   = (state_q == S_WAIT);
   assign MEM_rd     = rd_q;
   assign MEM_rd_vld = rd_vld_q;
   assign MEM_x_rd   = x_rd_q;
   assign MEM_err    = err_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access (TIMEOUT = 4) with a load-result scoreboard.
module tb_mem_access;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  EX_rd;
   logic        EX_rd_vld;
   logic [31:0] EX_x_rd;
   logic [31:0] EX_MEM_addr;
   logic [3:0]  EX_MEM_rden;
   logic        EX_MEM_rden_SEXT;
   logic [3:0]  EX_MEM_wren;
   logic [31:0] EX_MEM_wrdata;
   logic        dbus_req;
   logic        dbus_we;
   logic [31:0] dbus_addr;
   logic [3:0]  dbus_be;
   logic [31:0] dbus_wdata;
   logic        dbus_ack;
   logic [31:0] dbus_rdata;
   logic        mem_busy;
   logic [4:0]  MEM_rd;
   logic        MEM_rd_vld;
   logic [31:0] MEM_x_rd;
   logic        MEM_err;

   int n_checks = 0;
   int n_fail   = 0;
   logic [36:0] sb_q[$];

   always #5 clk = ~clk;

   mem_access #(.ADDR_W(32), .TIMEOUT(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .EX_rd(EX_rd), .EX_rd_vld(EX_rd_vld), .EX_x_rd(EX_x_rd),
      .EX_MEM_addr(EX_MEM_addr), .EX_MEM_rden(EX_MEM_rden),
      .EX_MEM_rden_SEXT(EX_MEM_rden_SEXT), .EX_MEM_wren(EX_MEM_wren),
      .EX_MEM_wrdata(EX_MEM_wrdata),
      .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
      .dbus_be(dbus_be), .dbus_wdata(dbus_wdata), .dbus_ack(dbus_ack),
      .dbus_rdata(dbus_rdata), .mem_busy(mem_busy),
      .MEM_rd(MEM_rd), .MEM_rd_vld(MEM_rd_vld), .MEM_x_rd(MEM_x_rd), .MEM_err(MEM_err)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic ex_idle();
      EX_rd            = 5'd0;
      EX_rd_vld        = 1'b0;
      EX_x_rd          = 32'h0;
      EX_MEM_addr      = 32'h0;
      EX_MEM_rden      = 4'b0;
      EX_MEM_rden_SEXT = 1'b0;
      EX_MEM_wren      = 4'b0;
      EX_MEM_wrdata    = 32'h0;
   endtask

   // Called just after a falling edge; returns at the falling edge where the result is visible.
   task automatic mem_op(input logic st, input logic [31:0] addr, input logic [3:0] lanes,
                         input logic sext, input logic [4:0] rd, input logic [31:0] wdat,
                         input logic [31:0] rdat, input int dly, input logic [31:0] exp_x);
      int busy;
      logic [36:0] e;
      EX_rd            = rd;
      EX_rd_vld        = 1'b1;
      EX_x_rd          = 32'hCAFE0000;
      EX_MEM_addr      = addr;
      EX_MEM_rden      = st ? 4'b0 : lanes;
      EX_MEM_wren      = st ? lanes : 4'b0;
      EX_MEM_rden_SEXT = sext;
      EX_MEM_wrdata    = wdat;
      if (!st) sb_q.push_back({rd, exp_x});
      @(negedge clk);
      chk("bus_req", 32'(dbus_req), 32'd1);
      chk("bus_we", 32'(dbus_we), 32'(st));
      chk("bus_addr", dbus_addr, {addr[31:2], 2'b00});
      chk("bus_be", 32'(dbus_be), 32'(lanes));
      busy = 0;
      for (int k = 0; k < dly; k++) begin
         if (k > 0) @(negedge clk);
         busy += int'(mem_busy);
         if (st) chk("st_wdata_hold", dbus_wdata, wdat);
         if (k == dly - 1) begin
            dbus_ack   = 1'b1;
            dbus_rdata = rdat;
         end
      end
      @(negedge clk);
      dbus_ack   = 1'b0;
      dbus_rdata = 32'h0;
      chk("busy_cycles", 32'(busy), 32'(dly));
      chk("busy_after_ack", 32'(mem_busy), 32'd0);
      chk("req_after_ack", 32'(dbus_req), 32'd0);
      chk("err_after_ack", 32'(MEM_err), 32'd0);
      if (st) begin
         chk("st_rd_vld", 32'(MEM_rd_vld), 32'd0);
      end else if (MEM_rd_vld === 1'b1 && sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk("ld_rd", 32'(MEM_rd), 32'(e[36:32]));
         chk("ld_data", MEM_x_rd, e[31:0]);
      end else begin
         chk("ld_rd_vld", 32'(MEM_rd_vld), 32'd1);
      end
      ex_idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_n      = 1'b0;
      dbus_ack   = 1'b0;
      dbus_rdata = 32'h0;
      ex_idle();
      #3;
      chk("rst_req", 32'(dbus_req), 32'd0);
      chk("rst_we", 32'(dbus_we), 32'd0);
      chk("rst_be", 32'(dbus_be), 32'd0);
      chk("rst_busy", 32'(mem_busy), 32'd0);
      chk("rst_rd_vld", 32'(MEM_rd_vld), 32'd0);
      chk("rst_err", 32'(MEM_err), 32'd0);
      chk("rst_x_rd", MEM_x_rd, 32'h0);
      chk("rst_addr", dbus_addr, 32'h0);
      #20;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Pass-through
      EX_rd = 5'd5; EX_rd_vld = 1'b1; EX_x_rd = 32'h1234;
      @(negedge clk);
      chk("pt_rd", 32'(MEM_rd), 32'd5);
      chk("pt_vld", 32'(MEM_rd_vld), 32'd1);
      chk("pt_data", MEM_x_rd, 32'h1234);
      chk("pt_req", 32'(dbus_req), 32'd0);
      ex_idle();
      @(negedge clk);
      chk("pt_vld_clear", 32'(MEM_rd_vld), 32'd0);

      // Loads and stores, issued back-to-back
      mem_op(1'b0, 32'h103, 4'b1000, 1'b1, 5'd7,  32'h0, 32'h80AABBCC, 3, 32'hFFFFFF80);
      mem_op(1'b0, 32'h100, 4'b1100, 1'b0, 5'd8,  32'h0, 32'h80010000, 2, 32'h00008001);
      mem_op(1'b0, 32'h104, 4'b1111, 1'b0, 5'd9,  32'h0, 32'hDEADBEEF, 1, 32'hDEADBEEF);
      mem_op(1'b0, 32'h108, 4'b0011, 1'b1, 5'd10, 32'h0, 32'h00008001, 1, 32'hFFFF8001);
      mem_op(1'b0, 32'h109, 4'b0010, 1'b1, 5'd11, 32'h0, 32'h00007F00, 2, 32'h0000007F);
      mem_op(1'b0, 32'h10A, 4'b0100, 1'b1, 5'd12, 32'h0, 32'h00FF0000, 1, 32'hFFFFFFFF);
      mem_op(1'b0, 32'h10C, 4'b0001, 1'b0, 5'd13, 32'h0, 32'h000000F0, 1, 32'h000000F0);
      mem_op(1'b1, 32'h202, 4'b0100, 1'b0, 5'd14, 32'h5A5A5A5A, 32'h0, 2, 32'h0);
      // Ack on the edge where the timeout would fire: normal completion
      mem_op(1'b0, 32'h110, 4'b1111, 1'b0, 5'd15, 32'h0, 32'h13572468, 4, 32'h13572468);

      // Timeout: ack never arrives
      EX_rd = 5'd16; EX_rd_vld = 1'b1; EX_MEM_addr = 32'h300; EX_MEM_rden = 4'b1111;
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         if (k > 0) @(negedge clk);
         chk("to_req_held", 32'(dbus_req), 32'd1);
         chk("to_err_quiet", 32'(MEM_err), 32'd0);
      end
      @(negedge clk);
      ex_idle();
      chk("to_req_drop", 32'(dbus_req), 32'd0);
      chk("to_err", 32'(MEM_err), 32'd1);
      chk("to_rd_vld", 32'(MEM_rd_vld), 32'd0);
      chk("to_busy", 32'(mem_busy), 32'd0);
      @(negedge clk);
      chk("to_err_pulse", 32'(MEM_err), 32'd0);

      // Reset in the middle of a wait
      EX_rd = 5'd17; EX_rd_vld = 1'b1; EX_MEM_addr = 32'h404; EX_MEM_rden = 4'b1111;
      @(negedge clk);
      chk("mr_req_before", 32'(dbus_req), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("mr_req", 32'(dbus_req), 32'd0);
      chk("mr_busy", 32'(mem_busy), 32'd0);
      chk("mr_rd_vld", 32'(MEM_rd_vld), 32'd0);
      chk("mr_x_rd", MEM_x_rd, 32'h0);
      ex_idle();
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      mem_op(1'b0, 32'h404, 4'b1111, 1'b0, 5'd18, 32'h0, 32'hA5A51234, 2, 32'hA5A51234);

`ifdef MEM_LANE_CHK_EN
      EX_rd = 5'd19; EX_rd_vld = 1'b1; EX_MEM_addr = 32'h400; EX_MEM_rden = 4'b0101;
      @(negedge clk);
      ex_idle();
      chk("lc_err", 32'(MEM_err), 32'd1);
      chk("lc_req", 32'(dbus_req), 32'd0);
      chk("lc_busy", 32'(mem_busy), 32'd0);
      chk("lc_rd_vld", 32'(MEM_rd_vld), 32'd0);
      @(negedge clk);
      chk("lc_err_pulse", 32'(MEM_err), 32'd0);
`else
      mem_op(1'b0, 32'h400, 4'b0101, 1'b0, 5'd19, 32'h0, 32'h11223344, 1, 32'h00220044);
`endif

      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
Memory-access stage that consumes the execute stage's registered load/store request (EX_MEM_addr, byte-lane rden/wren, rden_SEXT, wrdata) and the ALU writeback (EX_rd/EX_rd_vld/EX_x_rd).
- Memory requests drive a req/ack data bus and stall upstream while waiting.
- Load data is lane-aligned and zero- or sign-extended into MEM_x_rd.
- Non-memory results pass through with one-cycle latency.

Parameters:
ADDR_W, 32, width of dbus_addr; the low ADDR_W bits of EX_MEM_addr are used, with bits [1:0] forced to 0.
TIMEOUT, 0, maximum number of cycles to wait for dbus_ack; 0 means wait forever.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
EX_rd  in  5  destination register
EX_rd_vld  in  1  writeback valid
EX_x_rd  in  32  ALU result
EX_MEM_addr  in  32  byte address
EX_MEM_rden  in  4  load byte-lane enables
EX_MEM_rden_SEXT  in  1  sign-extend load
EX_MEM_wren  in  4  store byte-lane enables
EX_MEM_wrdata  in  32  lane-replicated store data
dbus_req  out  1  bus request
dbus_we  out  1  1 = write
dbus_addr  out  ADDR_W  word-aligned address
dbus_be  out  4  byte enables
dbus_wdata  out  32  write data
dbus_ack  in  1  transfer complete; dbus_rdata valid in the same cycle
dbus_rdata  in  32  read word
mem_busy  out  1  stall to upstream
MEM_rd  out  5  destination register
MEM_rd_vld  out  1  writeback valid
MEM_x_rd  out  32  writeback data
MEM_err  out  1  one-cycle error pulse (illegal lanes or timeout)

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - state = IDLE.
  - dbus_req, dbus_we, dbus_be, mem_busy, MEM_rd_vld, MEM_err = 0.
  - dbus_addr, dbus_wdata, MEM_rd, MEM_x_rd = 0.
  - Timeout counter = 0.
  - Any in-flight transfer is abandoned; the bus slave must tolerate req dropping.
- State machine: IDLE and WAIT. mem_busy = (state == WAIT), registered.
- IDLE, no lanes set (rden == 0 and wren == 0): pass-through.
  - At the next edge: MEM_rd <= EX_rd, MEM_rd_vld <= EX_rd_vld, MEM_x_rd <= EX_x_rd.
- IDLE, wren != 0 (store; takes priority if rden is also set):
  - At the edge: dbus_req <= 1, dbus_we <= 1, dbus_be <= wren, dbus_addr <= aligned address, dbus_wdata <= EX_MEM_wrdata.
  - Latch rd; MEM_rd_vld <= 0; go to WAIT.
- IDLE, rden != 0 (load):
  - Same as store, but with dbus_we <= 0 and dbus_be <= rden.
  - Latch rd, rd_vld, lane pattern and SEXT flag; MEM_rd_vld <= 0; go to WAIT.
- WAIT:
  - dbus_req and the other bus outputs are held stable until dbus_ack is sampled high.
  - EX_* inputs are ignored; upstream must hold its instruction while mem_busy = 1.
- WAIT with dbus_ack at an edge:
  - dbus_req <= 0; go to IDLE.
  - Load: MEM_x_rd <= extracted data; MEM_rd_vld <= latched rd_vld.
  - Store: MEM_rd_vld <= 0.
  - Minimum latency is 2 edges from request acceptance to MEM_x_rd valid.
  - Back-to-back: a new EX request may be accepted on the first IDLE cycle after ack.
- Load extraction:
  - 1111: the whole word.
  - 0011 / 1100: rdata[15:0] / rdata[31:16].
  - 0001 / 0010 / 0100 / 1000: byte 0 / 1 / 2 / 3.
  - Extension: SEXT = 1 replicates the top bit of the extracted field; otherwise zero-extend.
- Timeout (TIMEOUT > 0):
  - The counter increments on each WAIT cycle without ack.
  - On reaching TIMEOUT: drop req, return to IDLE, MEM_err = 1 for one cycle, MEM_rd_vld = 0.
  - Ack arriving on the same edge that timeout would fire wins: normal completion, no error.
- MEM_err is 0 except for the single-cycle pulses defined here.

Optional Feature:
MEM_LANE_CHK_EN
- Defined: a request is illegal if both rden and wren are nonzero, or if the active enable is not one of {0001, 0010, 0100, 1000, 0011, 1100, 1111}.
  - An illegal request produces no bus transaction, MEM_err = 1 for one cycle, MEM_rd_vld = 0, and state stays IDLE.
- Undefined: no lane check; store wins when both are set; an unlisted load pattern returns the full word masked to the enabled bytes, unshifted. MEM_err is driven only by timeout.

Test Plan:
- Pass-through: EX_rd = 5, rd_vld = 1, x_rd = 0x1234, no lanes -> next cycle MEM_rd = 5, MEM_rd_vld = 1, MEM_x_rd = 0x1234; dbus_req never asserted.
- LB sign-extend: addr 0x103, rden = 1000, SEXT = 1, ack 3 cycles later with rdata 0x80AABBCC -> MEM_x_rd = 0xFFFFFF80; dbus_addr = 0x100; mem_busy high exactly 3 cycles.
- LHU: rden = 1100, SEXT = 0, rdata 0x8001_0000 -> MEM_x_rd = 0x00008001. LW with ack in the first WAIT cycle -> 2-edge latency, data = rdata.
- SB: addr 0x202, wren = 0100, wrdata 0x5A5A5A5A -> dbus_we = 1, be = 0100, addr 0x200, data held until ack; MEM_rd_vld = 0.
- Reset mid-WAIT: rst_n low while dbus_req = 1 -> dbus_req, mem_busy and MEM_rd_vld go to 0 immediately without a clock edge; after release, the next load completes normally.
- TIMEOUT = 4, ack never comes -> req drops after 4 WAIT cycles, MEM_err pulses once. With MEM_LANE_CHK_EN, rden = 0101 -> MEM_err pulse, no dbus_req.
